// File: rtl/gate_exerciser_if.sv
// Bundles the sweep control, status and gate-facing signals of gate_exerciser.
// master is the exerciser side; slave is the environment (gate plus requester).
interface gate_exerciser_if #(
  parameter int unsigned N_IN = 1
);
  logic            start;
  logic [N_IN-1:0] x_out;
  logic            y_in;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] fail_vec;

  modport master (
    input  start, y_in,
    output x_out, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    output start, y_in,
    input  x_out, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/gate_exerciser.sv
// Sweeps every input vector of a combinational gate in ascending order, holds
// each for HOLD cycles, samples the gate output and scores it against EXPECT.
module gate_exerciser #(
  parameter int unsigned                N_IN   = 1,
  parameter int unsigned                HOLD   = 2,
  parameter logic [(2**N_IN)-1:0]       EXPECT = 2'b01
) (
  input logic              clk,
  input logic              rst,
  gate_exerciser_if.master bus
);

  localparam logic [N_IN-1:0] VEC_LAST  = {N_IN{1'b1}};
  localparam logic [7:0]      HOLD_LAST = 8'(HOLD - 1);
  localparam logic [N_IN:0]   ERR_MAX   = (N_IN + 1)'(2 ** N_IN);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [7:0]      hcnt_q, hcnt_d;
  logic [N_IN-1:0] x_out_q, x_out_d;
  logic [N_IN-1:0] fail_q, fail_d;
  logic [N_IN:0]   err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  logic sample;
  logic last_vec;
  logic mismatch;

  // The current vector has been stable at the gate for HOLD-1 full cycles.
  assign sample   = (state_q == RUN) && (hcnt_q == HOLD_LAST);
  assign last_vec = (vec_q == VEC_LAST);
  assign mismatch = (bus.y_in != EXPECT[vec_q]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      hcnt_q  <= '0;
      x_out_q <= '0;
      fail_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hcnt_q  <= hcnt_d;
      x_out_q <= x_out_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (sample && last_vec) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vec_d  = vec_q;
    hcnt_d = hcnt_q;
    fail_d = fail_q;
    err_d  = err_q;
    busy_d = busy_q;
    done_d = 1'b0;
    pass_d = pass_q;

    unique case (state_q)
      IDLE: begin
        vec_d  = '0;
        hcnt_d = '0;
        if (bus.start) begin
          err_d  = '0;
          fail_d = '0;
          pass_d = 1'b0;
          busy_d = 1'b1;
        end
      end
      RUN: begin
        if (!sample) begin
          hcnt_d = hcnt_q + 8'd1;
        end else begin
          if (mismatch) begin
            // An empty count means this is the first miss of the sweep.
            if (err_q == '0) fail_d = vec_q;
            if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          end
          if (last_vec) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (err_d == '0);
          end else begin
            vec_d  = vec_q + 1'b1;
            hcnt_d = '0;
          end
        end
      end
      default: ;
    endcase

    // Drive the vector that will be current after this edge so it is
    // presented to the gate for the whole hold window.
    x_out_d = (state_d == RUN) ? vec_d : '0;
  end

  assign bus.x_out     = x_out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Exercises a NOT-style (N_IN=1) and an AND-style (N_IN=2) exerciser against
// lookup-table gates, with a cycle-level reference model and a result scoreboard.
module tb_gate_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int cfg, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL cfg%0d %s: got %0d, expected %0d (t=%0t)", cfg, name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int N  = (gi == 0) ? 1 : 2;
    localparam int H  = (gi == 0) ? 2 : 3;
    localparam int NV = 1 << N;
    localparam int L  = NV * H;
    localparam logic [3:0]    EXP_W = (gi == 0) ? 4'b0001 : 4'b1000;
    localparam logic [NV-1:0] EXP   = EXP_W[NV-1:0];
    localparam logic [3:0]    BAD_W = (gi == 0) ? 4'b0010 : 4'b0000;
    localparam logic [NV-1:0] BAD   = BAD_W[NV-1:0];

    typedef struct {
      int err;
      int fail;
      int pass;
      int done_at;
    } res_t;

    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic [NV-1:0] tt    = EXP;
    bit            fin   = 1'b0;

    gate_exerciser_if #(.N_IN(N)) ifc ();
    assign ifc.start = start;
    assign ifc.y_in  = tt[ifc.x_out];

    gate_exerciser #(
      .N_IN  (N),
      .HOLD  (H),
      .EXPECT(EXP)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc)
    );

    int            cyc   = 0;
    int            k     = 0;
    bit            valid = 1'b0;
    logic [NV-1:0] tt_m  = '0;
    res_t          sb[$];

    // Results visible after edge c: vectors whose sample edge has passed are scored.
    function automatic res_t ref_at(input int c);
      res_t r;
      int   ns;
      r = '{0, 0, 0, 0};
      if (!valid || c < k) return r;
      ns = (c - k) / H;
      if (ns > NV) ns = NV;
      for (int i = 0; i < ns; i++) begin
        if (tt_m[i] != EXP[i]) begin
          if (r.err == 0) r.fail = i;
          r.err++;
        end
      end
      r.pass = (ns == NV && r.err == 0) ? 1 : 0;
      return r;
    endfunction

    // Reference model: decides at each edge whether a start is accepted.
    initial forever begin
      res_t r;
      @(posedge clk);
      cyc = cyc + 1;
      if (rst) begin
        valid = 1'b0;
        sb.delete();
      end else if (start && (!valid || cyc >= k + L + 1)) begin
        valid = 1'b1;
        k     = cyc;
        tt_m  = tt;
        r         = ref_at(k + L);
        r.done_at = k + L;
        sb.push_back(r);
      end
    end

    // Monitor: per-cycle status checks, and scoreboard pop on each done.
    initial forever begin
      res_t e;
      res_t f;
      bit   eb;
      @(posedge clk);
      #1;
      e  = ref_at(cyc);
      eb = valid && (cyc < k + L);
      check("busy", gi, int'(ifc.busy), int'(eb));
      check("x_out", gi, int'(ifc.x_out), eb ? (cyc - k) / H : 0);
      check("done", gi, int'(ifc.done), int'(valid && cyc == k + L));
      check("err_count", gi, int'(ifc.err_count), e.err);
      check("fail_vec", gi, int'(ifc.fail_vec), e.fail);
      check("pass", gi, int'(ifc.pass), e.pass);
      if (ifc.done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL cfg%0d sb_done: got done pulse, expected no pending sweep (t=%0t)", gi, $time);
        end else begin
          f = sb.pop_front();
          $display("cfg%0d sweep done at %0d: err=%0d fail_vec=%0d pass=%0d", gi, cyc,
                   ifc.err_count, ifc.fail_vec, ifc.pass);
          check("sb_err", gi, int'(ifc.err_count), f.err);
          check("sb_fail", gi, int'(ifc.fail_vec), f.fail);
          check("sb_pass", gi, int'(ifc.pass), f.pass);
          check("sb_latency", gi, cyc, f.done_at);
        end
      end
    end

    // mode 0: plain; 1: start held while busy then re-issued in the done cycle;
    // 2: reset two cycles into the sweep; 3: random start noise while busy.
    task automatic run_sweep(input logic [NV-1:0] t, input int mode);
      while (valid && cyc < k + L) @(negedge clk);
      tt    = t;
      start = 1'b1;
      @(negedge clk);
      case (mode)
        1: begin
          repeat (2) @(negedge clk);
          start = 1'b0;
          while (cyc < k + L) @(negedge clk);
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
        2: begin
          start = 1'b0;
          repeat (2) @(negedge clk);
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          repeat (L + 2) @(negedge clk);
        end
        3: begin
          while (cyc < k + L) begin
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
          end
          start = 1'b0;
        end
        default: start = 1'b0;
      endcase
    endtask

    initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_sweep(EXP, 0);
      run_sweep(BAD, 0);
      run_sweep(EXP, 1);
      run_sweep(BAD, 2);
      run_sweep(EXP, 3);
      for (int n = 0; n < 24; n++) begin
        run_sweep(NV'($urandom), int'($urandom_range(0, 3)));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      while (valid && cyc < k + L) @(negedge clk);
      repeat (3) @(negedge clk);
      check("sb_drained", gi, sb.size(), 0);
      fin = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin) && t < 50000) begin
      @(posedge clk);
      t++;
    end
    if (!(g_cfg[0].fin && g_cfg[1].fin)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got unfinished stimulus after %0d cycles, expected completion", t);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
